multicycle_cpu: RTL

//  Parametrised multi-cycle MIPS-subset CPU, one instruction per 6-state pass (FETCH..WB).

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/cpu_alu.sv | 30 +++
 rtl/multicycle_cpu.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the multi-cycle MIPS-subset CPU: opcode and funct
// codes, the 3-bit controller state encoding and the ALU operation select.
// No ports; imported by cpu_alu and multicycle_cpu.

package cpu_pkg;

  // Primary opcodes (ir[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type function codes (ir[5:0])
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  // Controller states; FETCH..WB form one instruction pass
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_READ   = 3'd3,
    ST_EXEC   = 3'd4,
    ST_MEM    = 3'd5,
    ST_WB     = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_SLT = 2'd2
  } alu_op_t;

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu
// Combinational ALU for the multi-cycle CPU. Add and subtract wrap modulo
// 2**DATA_W; SLT is a signed compare returning 0 or 1.
// Ports:
//   a, b  in  DATA_W  operands
//   op    in  alu_op_t operation select
//   y     out DATA_W  result

module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_cpu.sv
// multicycle_cpu
// Multi-cycle MIPS-subset CPU executing one instruction per six-state pass
// (FETCH, DECODE, READ, EXEC, MEM, WB). Instruction and data memories are
// loaded by a host while the core is idle or halted; start/done handshake.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   start                           begin execution at pc=0 (IDLE/HALT only)
//   prog_len                        halt once pc >= prog_len
//   imem_we/imem_addr/imem_wdata    host instruction memory write
//   dmem_we/dmem_addr/dmem_wdata    host data memory write
//   dbg_sel / dbg_val               combinational register read port
//   busy, done, err                 status (running, normal halt, trap halt)
//   pc_out                          current program counter
//   led                             copy of register OUT_REG, updated each WB

module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int IMEM_AW = 4,
  parameter int DMEM_AW = 4,
  parameter int OUT_REG = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [IMEM_AW:0]   prog_len,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_wdata,
  input  logic               dmem_we,
  input  logic [DMEM_AW-1:0] dmem_addr,
  input  logic [DATA_W-1:0]  dmem_wdata,
  input  logic [4:0]         dbg_sel,
  output logic [DATA_W-1:0]  dbg_val,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [IMEM_AW-1:0] pc_out,
  output logic [DATA_W-1:0]  led
);

  state_t state, state_next;

  logic [31:0]        imem [2**IMEM_AW];
  logic [DATA_W-1:0]  dmem [2**DMEM_AW];
  logic [DATA_W-1:0]  regs [32];

  logic [IMEM_AW-1:0] pc;
  logic [31:0]        ir;
  logic [DATA_W-1:0]  a_q, b_q, alu_q, load_q;
  logic [DMEM_AW-1:0] addr_q;
  logic               taken_q;

  // Decoded instruction fields and controls
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wb_dst;
  logic        valid, wb_en, wb_rd, use_imm, is_lw, is_sw, is_br, br_ne, is_j;
  alu_op_t     alu_op;

  logic [DATA_W-1:0]  alu_b, alu_y, wb_data, led_next;
  logic [DMEM_AW-1:0] eff_addr;
  logic [IMEM_AW-1:0] pc_seq, br_target, pc_wb;
  logic               finish, host_ok, wb_write;
  logic               unused_bits;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign unused_bits = ^ir[10:6];

  // Decode is purely a function of ir, which is stable from FETCH to WB
  always_comb begin
    valid   = 1'b0;
    wb_en   = 1'b0;
    wb_rd   = 1'b0;
    use_imm = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_br   = 1'b0;
    br_ne   = 1'b0;
    is_j    = 1'b0;
    alu_op  = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin valid = 1'b1; wb_en = 1'b1; wb_rd = 1'b1; alu_op = ALU_ADD; end
          FN_SUBU: begin valid = 1'b1; wb_en = 1'b1; wb_rd = 1'b1; alu_op = ALU_SUB; end
          FN_SLT:  begin valid = 1'b1; wb_en = 1'b1; wb_rd = 1'b1; alu_op = ALU_SLT; end
          default: ;
        endcase
      end
      OP_ADDIU: begin valid = 1'b1; wb_en = 1'b1; use_imm = 1'b1; end
      OP_LW:    begin valid = 1'b1; wb_en = 1'b1; is_lw = 1'b1; end
      OP_SW:    begin valid = 1'b1; is_sw = 1'b1; end
      OP_BEQ:   begin valid = 1'b1; is_br = 1'b1; end
      OP_BNE:   begin valid = 1'b1; is_br = 1'b1; br_ne = 1'b1; end
      OP_J:     begin valid = 1'b1; is_j = 1'b1; end
      default: ;
    endcase
  end

  assign alu_b = use_imm ? ir[DATA_W-1:0] : b_q;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .a  (a_q),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y)
  );

  // Only the low address bits of rs+imm matter, so the address is formed at
  // memory width; the sign-extended offset reduces to its low bits mod depth.
  assign eff_addr  = DMEM_AW'(a_q) + ir[DMEM_AW-1:0];
  assign pc_seq    = pc + IMEM_AW'(1);
  assign br_target = pc_seq + ir[IMEM_AW-1:0];
  assign pc_wb     = is_j ? ir[IMEM_AW-1:0] : ((is_br && taken_q) ? br_target : pc_seq);
  assign finish    = {1'b0, pc_wb} >= prog_len;

  assign wb_dst   = wb_rd ? rd : rt;
  assign wb_data  = is_lw ? load_q : alu_q;
  assign wb_write = valid && wb_en && (wb_dst != 5'd0);
  assign led_next = (wb_write && (wb_dst == 5'(OUT_REG))) ? wb_data : regs[OUT_REG];

  assign host_ok = (state == ST_IDLE) || (state == ST_HALT);
  assign busy    = !host_ok;
  assign pc_out  = pc;
  assign dbg_val = regs[dbg_sel];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; an invalid instruction or reaching prog_len halts in WB
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) state_next = (prog_len == '0) ? ST_HALT : ST_FETCH;
      end
      ST_FETCH:  state_next = ST_DECODE;
      ST_DECODE: state_next = ST_READ;
      ST_READ:   state_next = ST_EXEC;
      ST_EXEC:   state_next = ST_MEM;
      ST_MEM:    state_next = ST_WB;
      ST_WB:     state_next = (!valid || finish) ? ST_HALT : ST_FETCH;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Datapath registers, register file and status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= '0;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      load_q  <= '0;
      addr_q  <= '0;
      taken_q <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      led     <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            pc   <= '0;
            done <= (prog_len == '0);
            err  <= 1'b0;
          end
        end
        ST_FETCH: ir <= imem[pc];
        ST_READ: begin
          a_q <= regs[rs];
          b_q <= regs[rt];
        end
        ST_EXEC: begin
          alu_q   <= alu_y;
          addr_q  <= eff_addr;
          taken_q <= (a_q == b_q) != br_ne;
        end
        ST_MEM: begin
          if (is_lw) load_q <= dmem[addr_q];
        end
        ST_WB: begin
          led <= led_next;
          if (!valid) begin
            err <= 1'b1;
          end else begin
            pc <= pc_wb;
            if (finish) done <= 1'b1;
            if (wb_write) regs[wb_dst] <= wb_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Memories are never cleared by reset; a store is suppressed during reset
  always_ff @(posedge clk) begin
    if (host_ok && imem_we) imem[imem_addr] <= imem_wdata;
    if (host_ok && dmem_we) dmem[dmem_addr] <= dmem_wdata;
    else if (rst_n && (state == ST_MEM) && is_sw) dmem[addr_q] <= b_q;
  end

endmodule
